arbitro_display: RTL and testbench
==================================

Name: arbitro_display

Overview:
- Shares the 4-digit 7-segment display controller among up to four requesters.
- Requester data is 16 bits, four BCD/hex nibbles; the block registers it onto the four nibble inputs of the display controller.
- Each grant lasts a guaranteed minimum time so the value is readable.
- Grants rotate round-robin among active requesters, e.g. counter, sensor reading or error code.

Parameters:
N_REQ, 3, number of requesters, legal range 2..4
HOLD_CYC, 50000000, minimum i_Clk cycles an owner keeps the display (1 s at 50 MHz), must be >= 1
IDLE_DATA, 16'h0000, value shown when nobody owns the display

Ports:
i_Clk  input  1  system clock, all logic on rising edge
i_Rst  input  1  asynchronous, active-high reset
i_Req  input  N_REQ  request per requester, level-sensitive
i_Datos  input  16*N_REQ  flattened data; requester r occupies bits [16r+15:16r]
o_Gnt  output  N_REQ  one-hot grant, all zero when idle
o_Dueno  output  2  index of current/last owner
o_Activo  output  1  high while in MUESTRA
o_Datos1  output  4  nibble [3:0] of displayed word
o_Datos2  output  4  nibble [7:4]
o_Datos3  output  4  nibble [11:8]
o_Datos4  output  4  nibble [15:12]

Behaviour:
- Reset (async, immediate, mid-operation included): state IDLE, o_Gnt=0, o_Dueno=0, o_Activo=0, o_Datos4..1 = IDLE_DATA nibbles, rotation pointer ptr=0, hold counter=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Arbitration function ARB(start): scan indices start, start+1, ... mod N_REQ. The first index with i_Req set wins; otherwise none.
- State IDLE: if any i_Req bit is set, winner w=ARB(ptr). Next cycle:
  - state=MUESTRA, o_Gnt=one-hot(w), o_Dueno=w, o_Activo=1.
  - o_Datos = slice w, counter=HOLD_CYC-1.
  - Latency is 1 cycle from req to grant and data.
  - With no request, stay in IDLE; outputs hold IDLE_DATA.
- State MUESTRA, counter != 0: counter decrements each cycle.
  - While i_Req[owner]=1, o_Datos reload every cycle from the owner slice (live update, 1-cycle latency).
  - If i_Req[owner] drops: o_Gnt clears next cycle, o_Datos freeze at last loaded value, and the hold keeps running (minimum display time is preserved).
  - Other requests are ignored until expiry.
- State MUESTRA, counter == 0 (expiry): w=ARB(owner+1 mod N_REQ).
  - w == owner (only the owner requests): reload counter=HOLD_CYC-1, keep grant.
  - w != owner: next cycle o_Gnt=one-hot(w), o_Dueno=w, o_Datos=slice w, counter reloaded. Zero-gap handover; ptr=w+1 mod N_REQ.
  - No requests: next cycle IDLE, o_Gnt=0, o_Activo=0, o_Datos=IDLE_DATA; ptr=owner+1 mod N_REQ; o_Dueno holds last owner.
- HOLD_CYC=1: expiry evaluated every MUESTRA cycle, giving per-cycle rotation.
- o_Gnt is never more than one-hot. A grant is never given to a requester whose i_Req is low in the deciding cycle.
- Requester re-raising req after dropping during its own hold: grant does not return before expiry; it competes normally at expiry.
- Counter width is $clog2(HOLD_CYC+1). Pointer and index arithmetic wrap mod N_REQ; indices >= N_REQ are never produced.

Test Plan (N_REQ=3, HOLD_CYC=4, IDLE_DATA=16'h0000):
1. i_Rst pulse asserted mid-cycle -> outputs at reset values immediately, before the next clock edge: o_Gnt=000, o_Activo=0, o_Datos4..1=0,0,0,0.
2. i_Req=010, slice1=16'h1234 at edge 0 -> edge 1: o_Gnt=010, o_Dueno=1, o_Datos4..1=1,2,3,4. Slice1 changed to 16'h5678 -> display shows 5,6,7,8 one cycle later.
3. i_Req=111 held with distinct data per slice -> owners 0,1,2,0,... each exactly 4 cycles, no cycle with o_Gnt=000.
4. Only req0 held for 20 cycles -> o_Gnt=001 continuously, o_Activo=1, counter reloads every 4 cycles.
5. Owner 0 drops req on its 2nd hold cycle while req2=1 -> o_Gnt=000 next cycle, o_Datos frozen, o_Activo=1. o_Gnt=100 with slice2 data exactly when the 4-cycle hold ends.
6. All req drop during a hold -> display held until expiry, then IDLE with o_Datos=0000 and o_Activo=0. Next req from requester 0 while ptr=1 and req1 is also set -> requester 1 wins.

Source files
------------

// File: rtl/arbitro_display.sv
// Round-robin owner of the 4-digit 7-segment display: each owner keeps it for at least
// HOLD_CYC cycles, and its 16-bit word is registered onto the four nibble outputs.
module arbitro_display #(
   parameter int          N_REQ     = 3,
   parameter int          HOLD_CYC  = 50000000,
   parameter logic [15:0] IDLE_DATA = 16'h0000
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic [N_REQ-1:0]   i_Req,
   input  logic [16*N_REQ-1:0] i_Datos,
   output logic [N_REQ-1:0]   o_Gnt,
   output logic [1:0]         o_Dueno,
   output logic               o_Activo,
   output logic [3:0]         o_Datos1,
   output logic [3:0]         o_Datos2,
   output logic [3:0]         o_Datos3,
   output logic [3:0]         o_Datos4
);

   localparam int CNT_W = $clog2(HOLD_CYC + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYC - 1);

   typedef enum logic {IDLE, MUESTRA} state_t;

   state_t             state;
   logic [N_REQ-1:0]   gnt;
   logic [1:0]         dueno;
   logic [1:0]         ptr;
   logic               activo;
   logic [15:0]        datos;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         req4;
   logic [2:0]         arb_idle;
   logic [2:0]         arb_exp;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (int'(i) + 1 >= N_REQ) ? 2'd0 : i + 2'd1;
   endfunction

   // Returns {found, index}; the scan starts at 'start' and wraps modulo N_REQ.
   function automatic logic [2:0] arb(input logic [3:0] req, input logic [1:0] start);
      logic [1:0] idx;
      logic       found;
      logic [1:0] win;
      idx   = start;
      found = 1'b0;
      win   = 2'd0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
         idx = next_idx(idx);
      end
      return {found, win};
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [1:0] i);
      logic [3:0] t;
      t = 4'b0001 << i;
      return t[N_REQ-1:0];
   endfunction

   function automatic logic [15:0] slice(input logic [16*N_REQ-1:0] d, input logic [1:0] i);
      return d[16*int'(i) +: 16];
   endfunction

   always_comb begin
      req4     = 4'(i_Req);
      arb_idle = arb(req4, ptr);
      arb_exp  = arb(req4, next_idx(dueno));
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state  <= IDLE;
         gnt    <= '0;
         dueno  <= 2'd0;
         ptr    <= 2'd0;
         activo <= 1'b0;
         datos  <= IDLE_DATA;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_idle[2]) begin
                  state  <= MUESTRA;
                  gnt    <= onehot(arb_idle[1:0]);
                  dueno  <= arb_idle[1:0];
                  activo <= 1'b1;
                  datos  <= slice(i_Datos, arb_idle[1:0]);
                  cnt    <= RELOAD;
               end
            end
            MUESTRA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
                  // Once the owner lets go, the grant stays off until expiry; the word freezes.
                  if (!req4[dueno])
                     gnt <= '0;
                  else if (|gnt)
                     datos <= slice(i_Datos, dueno);
               end else if (!arb_exp[2]) begin
                  state  <= IDLE;
                  gnt    <= '0;
                  activo <= 1'b0;
                  datos  <= IDLE_DATA;
                  ptr    <= next_idx(dueno);
               end else begin
                  cnt   <= RELOAD;
                  gnt   <= onehot(arb_exp[1:0]);
                  dueno <= arb_exp[1:0];
                  datos <= slice(i_Datos, arb_exp[1:0]);
                  if (arb_exp[1:0] != dueno)
                     ptr <= next_idx(arb_exp[1:0]);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_Gnt    = gnt;
   assign o_Dueno  = dueno;
   assign o_Activo = activo;
   assign o_Datos1 = datos[3:0];
   assign o_Datos2 = datos[7:4];
   assign o_Datos3 = datos[11:8];
   assign o_Datos4 = datos[15:12];

endmodule

// File: tb/tb_arbitro_display.sv
// Scoreboard bench for arbitro_display: a cycle-level reference model queues the expected
// outputs for every clock, and a monitor on the falling edge compares them.
module tb_arbitro_display;

   localparam int          N    = 3;
   localparam int          HOLD = 4;
   localparam logic [15:0] IDLE = 16'h0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = '0;
   logic [47:0] datos = '0;
   logic [2:0]  gnt;
   logic [1:0]  dueno;
   logic        activo;
   logic [3:0]  d1, d2, d3, d4;

   int errors = 0;
   int checks = 0;

   arbitro_display #(.N_REQ(N), .HOLD_CYC(HOLD), .IDLE_DATA(IDLE)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Datos(datos),
      .o_Gnt(gnt), .o_Dueno(dueno), .o_Activo(activo),
      .o_Datos1(d1), .o_Datos2(d2), .o_Datos3(d3), .o_Datos4(d4)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  gnt;
      logic [1:0]  dueno;
      logic        activo;
      logic [15:0] data;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] sl(input int i);
      return datos[16*i +: 16];
   endfunction

   // First requester found scanning from s upward, wrapping; -1 when nobody asks.
   function automatic int pick(input logic [2:0] r, input int s);
      for (int k = 0; k < N; k++)
         if (r[(s + k) % N]) return (s + k) % N;
      return -1;
   endfunction

   // Reference model: 'age' counts hold cycles served by the current owner (1..HOLD).
   bit          m_busy, m_shown;
   int          m_own, m_age, m_ptr, m_w;
   logic [15:0] m_disp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_shown = 0; m_own = 0; m_age = 0; m_ptr = 0; m_disp = IDLE;
         q.delete();
      end else begin
         if (!m_busy) begin
            m_w = pick(req, m_ptr);
            if (m_w >= 0) begin
               m_busy = 1; m_shown = 1; m_own = m_w; m_age = 1; m_disp = sl(m_w);
            end
         end else if (m_age < HOLD) begin
            m_age++;
            if (!req[m_own]) m_shown = 0;
            else if (m_shown) m_disp = sl(m_own);
         end else begin
            m_w = pick(req, (m_own + 1) % N);
            if (m_w < 0) begin
               m_busy = 0; m_shown = 0; m_ptr = (m_own + 1) % N; m_disp = IDLE;
            end else begin
               if (m_w != m_own) m_ptr = (m_w + 1) % N;
               m_own = m_w; m_age = 1; m_shown = 1; m_disp = sl(m_w);
            end
         end
         q.push_back({m_shown ? 3'(3'b001 << m_own) : 3'b000, 2'(m_own), m_busy, m_disp});
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && q.size() > 0) begin
         e = q.pop_front();
         chk("gnt", 32'(gnt), 32'(e.gnt));
         chk("dueno", 32'(dueno), 32'(e.dueno));
         chk("activo", 32'(activo), 32'(e.activo));
         chk("datos", 32'({d4, d3, d2, d1}), 32'(e.data));
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'h0);
      chk({tag, "_dueno"}, 32'(dueno), 32'h0);
      chk({tag, "_activo"}, 32'(activo), 32'h0);
      chk({tag, "_datos"}, 32'({d4, d3, d2, d1}), 32'(IDLE));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_pulse");
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 check_reset_outputs("rst_init");
      rst = 1'b0;

      // Single requester with live data update
      @(negedge clk);
      datos = {16'hCCCC, 16'h1234, 16'hAAAA};
      req   = 3'b010;
      @(negedge clk);
      datos[31:16] = 16'h5678;
      repeat (3) @(negedge clk);

      // All requesting: strict rotation with zero-gap handover
      req = 3'b111;
      repeat (16) begin
         datos = {4'h2, 12'($urandom), 4'h1, 12'($urandom), 4'h0, 12'($urandom)};
         @(negedge clk);
      end

      // Lone requester keeps the display across reloads
      req = 3'b001;
      repeat (20) @(negedge clk);
      req = 3'b000;
      repeat (8) @(negedge clk);

      // Owner 0 drops on its second hold cycle while requester 2 waits
      pulse_reset();
      datos = {16'h2222, 16'h1111, 16'h0ABC};
      req   = 3'b101;
      repeat (2) @(negedge clk);
      req = 3'b100;
      datos[15:0] = 16'h0DEF;
      repeat (8) @(negedge clk);
      req = 3'b000;
      repeat (10) @(negedge clk);

      // Everyone drops mid-hold, then pointer favours requester 1
      req = 3'b001;
      @(negedge clk);
      req = 3'b000;
      repeat (6) @(negedge clk);
      req = 3'b011;
      @(negedge clk);
      chk("ptr_winner", 32'(dueno), 32'd1);
      repeat (5) @(negedge clk);

      // Randomized traffic
      repeat (500) begin
         if ($urandom_range(3) == 0) req = 3'($urandom_range(7));
         datos = {16'($urandom), 16'($urandom), 16'($urandom)};
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a cycle while busy
      req = 3'b111;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_reset_outputs("rst_mid");
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
